core_run_ctrl: RTL and testbench

Synthesisable run controller for the single-cycle ARM core. It replaces the fixed reset-then-wait sequence with a parametrised controller. It holds the core in reset for a programmable number of cycles, then releases it. It counts executed cycles and stops the core on a halt, an external stop, or a cycle budget, and reports which of these ended the run. It sits between the board/top level and the core's reset and enable inputs.

---
 rtl/core_run_ctrl_pkg.sv | 33 +++
 rtl/run_ctrl_sat_counter.sv | 39 +++
 rtl/core_run_ctrl.sv | 124 ++++++++++++
 tb/tb_core_run_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/core_run_ctrl_pkg.sv
// Shared types for the core run controller: FSM states, end-of-run cause
// encodings, default counter width and the exit arbitration helper.
package core_run_ctrl_pkg;

  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HOLD = 2'b01,
    ST_RUN  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_HALT    = 2'b01,
    CAUSE_STOP    = 2'b10,
    CAUSE_TIMEOUT = 2'b11
  } cause_e;

  // Resolve simultaneous exit reasons: halt beats stop beats timeout.
  // Only meaningful when at least one exit reason is active.
  function automatic cause_e pick_cause(input logic halt, input logic stop_req);
    if (halt) begin
      return CAUSE_HALT;
    end
    if (stop_req) begin
      return CAUSE_STOP;
    end
    return CAUSE_TIMEOUT;
  endfunction

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Sticks at all-ones instead of wrapping so long runs never report a small count.
module run_ctrl_sat_counter
  import core_run_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register, cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/core_run_ctrl.sv
// Run controller for the single-cycle core: holds the core in reset for
// RST_HOLD cycles after start, runs it while counting cycles, and freezes it
// on halt, external stop or cycle budget (MAX_CYCLES, 0 = unbounded).
// Optional retired-instruction counter: define CORE_RUN_CTRL_INSTR_CNT_EN.
module core_run_ctrl
  import core_run_ctrl_pkg::*;
#(
  parameter int RST_HOLD   = 2,
  parameter int MAX_CYCLES = 0,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             core_halt,
  output logic             core_rst_n,
  output logic             core_en,
  output logic             run,
  output logic             done,
  output logic [1:0]       cause,
  output logic [CNT_W-1:0] cycle_cnt
`ifdef CORE_RUN_CTRL_INSTR_CNT_EN
  ,
  input  logic             instr_retire,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  localparam logic [7:0]       HOLD_INIT = 8'(RST_HOLD - 1);
  // Value of cycle_cnt during the last budgeted RUN cycle.
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(MAX_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  cause_e     cause_q, cause_d;
  logic       cnt_clr;
  logic       cnt_inc;
  logic       tmo_hit;
  logic       exit_run;

  assign tmo_hit  = (MAX_CYCLES != 0) && (cycle_cnt == TMO_LAST);
  assign exit_run = core_halt || stop || tmo_hit;

  // Next-state logic, hold countdown, cause capture and counter controls.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cause_d = cause_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_HOLD;
          hold_d  = HOLD_INIT;
          cause_d = CAUSE_NONE;
          cnt_clr = 1'b1;
        end
      end
      ST_HOLD: begin
        if (hold_q == 8'd0) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      ST_RUN: begin
        // The exiting cycle is still counted, so a K-cycle run reports K.
        cnt_inc = 1'b1;
        if (exit_run) begin
          state_d = ST_DONE;
          cause_d = pick_cause(core_halt, stop);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, hold counter and cause registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hold_q  <= 8'd0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cause_q <= cause_d;
    end
  end

  // Outputs decode the state register only; no input reaches an output.
  assign core_rst_n = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign core_en    = (state_q == ST_RUN);
  assign run        = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign cause      = cause_q;

  run_ctrl_sat_counter #(
    .CNT_W (CNT_W)
  ) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .cnt_o (cycle_cnt)
  );

`ifdef CORE_RUN_CTRL_INSTR_CNT_EN
  run_ctrl_sat_counter #(
    .CNT_W (CNT_W)
  ) u_instr_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc && instr_retire),
    .cnt_o (instr_cnt)
  );
`endif

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl. Two instances share stimulus: A has a 10-cycle
// budget and 32-bit counters, B is unbounded with 3-bit counters so that
// saturation is reachable. Expected results come from per-run arithmetic
// (exit cycle = earliest of halt/stop/budget) rather than a cycle model.
module tb_core_run_ctrl;

  localparam int HOLD = 2;
  localparam int MAXA = 10;
  localparam int SATB = 7;

  logic clk = 1'b0;
  logic rst, start, stop, core_halt;
  logic a_rstn, a_en, a_run, a_done;
  logic b_rstn, b_en, b_run, b_done;
  logic [1:0]  a_cause, b_cause;
  logic [31:0] a_cnt;
  logic [2:0]  b_cnt;
  logic instr_retire;
`ifdef CORE_RUN_CTRL_INSTR_CNT_EN
  logic [31:0] a_icnt;
  logic [2:0]  b_icnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  core_run_ctrl #(.RST_HOLD(HOLD), .MAX_CYCLES(MAXA), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .core_halt(core_halt),
    .core_rst_n(a_rstn), .core_en(a_en), .run(a_run), .done(a_done),
    .cause(a_cause), .cycle_cnt(a_cnt)
`ifdef CORE_RUN_CTRL_INSTR_CNT_EN
    , .instr_retire(instr_retire), .instr_cnt(a_icnt)
`endif
  );

  core_run_ctrl #(.RST_HOLD(HOLD), .MAX_CYCLES(0), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .core_halt(core_halt),
    .core_rst_n(b_rstn), .core_en(b_en), .run(b_run), .done(b_done),
    .cause(b_cause), .cycle_cnt(b_cnt)
`ifdef CORE_RUN_CTRL_INSTR_CNT_EN
    , .instr_retire(instr_retire), .instr_cnt(b_icnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output of one instance (d=0 -> A, d=1 -> B).
  task automatic chk_dut(input int d, input string ph, input bit e_rstn, input bit e_en,
                         input bit e_run, input bit e_done, input int e_cause,
                         input int e_cnt, input int e_icnt);
    if (d == 0) begin
      chk({ph, "/A.core_rst_n"}, 64'(a_rstn), 64'(e_rstn));
      chk({ph, "/A.core_en"},    64'(a_en),   64'(e_en));
      chk({ph, "/A.run"},        64'(a_run),  64'(e_run));
      chk({ph, "/A.done"},       64'(a_done), 64'(e_done));
      chk({ph, "/A.cause"},      64'(a_cause), 64'(e_cause));
      chk({ph, "/A.cycle_cnt"},  64'(a_cnt),  64'(e_cnt));
`ifdef CORE_RUN_CTRL_INSTR_CNT_EN
      chk({ph, "/A.instr_cnt"},  64'(a_icnt), 64'(e_icnt));
`endif
    end else begin
      chk({ph, "/B.core_rst_n"}, 64'(b_rstn), 64'(e_rstn));
      chk({ph, "/B.core_en"},    64'(b_en),   64'(e_en));
      chk({ph, "/B.run"},        64'(b_run),  64'(e_run));
      chk({ph, "/B.done"},       64'(b_done), 64'(e_done));
      chk({ph, "/B.cause"},      64'(b_cause), 64'(e_cause));
      chk({ph, "/B.cycle_cnt"},  64'(b_cnt),  64'(e_cnt));
`ifdef CORE_RUN_CTRL_INSTR_CNT_EN
      chk({ph, "/B.instr_cnt"},  64'(b_icnt), 64'(e_icnt));
`endif
    end
    if (e_icnt < 0) n_fail++;  // never true; keeps e_icnt referenced in every build
  endtask

  // Reset, IDLE and HOLD all look alike from outside: everything zero.
  task automatic chk_off(input string ph);
    chk_dut(0, ph, 0, 0, 0, 0, 0, 0, 0);
    chk_dut(1, ph, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic int sat(input int v);
    return (v > SATB) ? SATB : v;
  endfunction

  // One run. h_at/s_at: RUN cycle (1-based) at which core_halt/stop rise and
  // stay high (0 = never; at least one must be nonzero so B terminates).
  // rmask: instr_retire per RUN cycle (bit i-1 = cycle i), 0 = random.
  task automatic do_run(input string nm, input int h_at, input int s_at,
                        input bit stop_in_hold, input int glitch_at,
                        input logic [31:0] rmask);
    int first, c_hs, ka, ca, kb, cb, len;
    int cum[0:40];
    bit ret[1:40];
    first = h_at;
    if (s_at != 0 && (first == 0 || s_at < first)) first = s_at;
    c_hs = (h_at != 0 && h_at == first) ? 1 : 2;
    if (first != 0 && first <= MAXA) begin ka = first; ca = c_hs; end
    else begin ka = MAXA; ca = 3; end
    kb = first;
    cb = c_hs;
    len = (ka > kb) ? ka : kb;
    cum[0] = 0;
    for (int i = 1; i <= 40; i++) begin
      ret[i] = (rmask != 0) ? ((i <= 32) ? rmask[i-1] : 1'b0) : 1'($urandom);
      cum[i] = cum[i-1] + int'(ret[i]);
    end
    if (glitch_at > ka || glitch_at > kb) glitch_at = 0;

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 1; j <= HOLD; j++) begin
      stop = stop_in_hold;
      chk_off({nm, ".hold"});
      @(negedge clk);
    end
    for (int i = 1; i <= len; i++) begin
      core_halt    = (h_at != 0) && (i >= h_at);
      stop         = (s_at != 0) && (i >= s_at);
      start        = (i == glitch_at);
      instr_retire = ret[i];
      if (i <= ka) chk_dut(0, {nm, ".run"}, 1, 1, 1, 0, 0, i - 1, cum[i-1]);
      else         chk_dut(0, {nm, ".done"}, 1, 0, 0, 1, ca, ka, cum[ka]);
      if (i <= kb) chk_dut(1, {nm, ".run"}, 1, 1, 1, 0, 0, sat(i - 1), sat(cum[i-1]));
      else         chk_dut(1, {nm, ".done"}, 1, 0, 0, 1, cb, sat(kb), sat(cum[kb]));
      @(negedge clk);
    end
    start = 1'b0;
    chk_dut(0, {nm, ".end"}, 1, 0, 0, 1, ca, ka, cum[ka]);
    chk_dut(1, {nm, ".end"}, 1, 0, 0, 1, cb, sat(kb), sat(cum[kb]));
    core_halt = 1'b0;
    stop = 1'b0;
    instr_retire = 1'b0;
    @(negedge clk);
    chk_dut(0, {nm, ".hold_done"}, 1, 0, 0, 1, ca, ka, cum[ka]);
    chk_dut(1, {nm, ".hold_done"}, 1, 0, 0, 1, cb, sat(kb), sat(cum[kb]));
  endtask

  initial begin
    int h, s;
    rst = 1'b1; start = 1'b0; stop = 1'b0; core_halt = 1'b0; instr_retire = 1'b0;
    repeat (3) @(negedge clk);
    chk_off("reset");
    rst = 1'b0;
    // IDLE ignores stop/halt; core stays in reset.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      stop = 1'($urandom);
      core_halt = 1'($urandom);
      chk_off("idle");
    end
    stop = 1'b0;
    core_halt = 1'b0;

    do_run("halt7",    7, 0,  0, 0, 32'h0);
    do_run("timeout",  0, 13, 0, 4, 32'h0);
    do_run("simul",    5, 5,  0, 0, 32'h0);
    do_run("halt_tmo", 10, 0, 0, 0, 32'h0);
    do_run("stop_hs",  0, 3,  1, 2, 32'h0);
    do_run("halt1",    1, 0,  1, 0, 32'h0);
    do_run("retire",   0, 8,  0, 0, 32'hB5);
    do_run("stop_tmo", 0, 10, 0, 0, 32'hFFFF);

    // Asynchronous reset in RUN cycle 4, then a clean restart.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (HOLD) @(negedge clk);
    repeat (3) @(negedge clk);
    chk_dut(0, "pre_rst", 1, 1, 1, 0, 0, 3, 0);
    rst = 1'b1;
    #1;
    chk_off("midrun_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_off("after_rst");
    do_run("clean", 6, 0, 0, 0, 32'h0);

    for (int r = 0; r < 12; r++) begin
      h = int'($urandom_range(0, 14));
      s = int'($urandom_range(0, 14));
      if (h == 0 && s == 0) s = int'($urandom_range(1, 14));
      do_run("rand", h, s, 1'($urandom), int'($urandom_range(0, 6)), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
